jmp_cond_seq: RTL and testbench

Sequential, parametrised successor to the combinational branch-condition evaluator. It resolves Jcc and the CX-family ops (JCXZ/LOOP/LOOPZ/LOOPNZ), performing the count decrement itself, and adds a REP/REPZ/REPNZ string-iteration controller. Sits between the decoder/microsequencer and the register file; takes a request with valid/ready handshake and returns a registered decision plus the updated count.

---
 rtl/jmp_cond_pkg.sv | 31 +++
 rtl/jmp_cond_eval.sv | 34 +++
 rtl/jmp_cond_seq.sv | 175 +++++++++++++++++
 tb/tb_jmp_cond_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/jmp_cond_pkg.sv
// Shared encodings for the branch-condition / string-iteration sequencer.
// Op codes, CX/REP sub-codes, flag bit positions and the controller state enum.
package jmp_cond_pkg;

  localparam logic [1:0] OP_JCC = 2'b00;
  localparam logic [1:0] OP_CX  = 2'b01;
  localparam logic [1:0] OP_REP = 2'b10;

  localparam logic [1:0] CX_JCXZ   = 2'b00;
  localparam logic [1:0] CX_LOOP   = 2'b01;
  localparam logic [1:0] CX_LOOPZ  = 2'b10;
  localparam logic [1:0] CX_LOOPNZ = 2'b11;

  localparam logic [1:0] REP_Z  = 2'b10;
  localparam logic [1:0] REP_NZ = 2'b11;

  // Flag vector is {of,sf,zf,pf,cf}
  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 1;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_SF = 3;
  localparam int FLAG_OF = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_REP_CHK = 2'b01,
    S_REP_RUN = 2'b10,
    S_DONE    = 2'b11
  } state_e;

endpackage

// File: rtl/jmp_cond_eval.sv
// Combinational x86 cccc condition evaluator: even codes test a predicate,
// odd codes test its complement.
module jmp_cond_eval
  import jmp_cond_pkg::*;
#(
  parameter int FLAGW = 5
) (
  input  logic [FLAGW-1:0] flags,
  input  logic [3:0]       cond,
  output logic             taken
);

  logic base;
  logic sf_ne_of;

  assign sf_ne_of = flags[FLAG_SF] ^ flags[FLAG_OF];

  always_comb begin
    base = 1'b0;
    case (cond[3:1])
      3'd0:    base = flags[FLAG_OF];
      3'd1:    base = flags[FLAG_CF];
      3'd2:    base = flags[FLAG_ZF];
      3'd3:    base = flags[FLAG_CF] | flags[FLAG_ZF];
      3'd4:    base = flags[FLAG_SF];
      3'd5:    base = flags[FLAG_PF];
      3'd6:    base = sf_ne_of;
      default: base = flags[FLAG_ZF] | sf_ne_of;
    endcase
  end

  assign taken = base ^ cond[0];

endmodule

// File: rtl/jmp_cond_seq.sv
// Sequential branch resolver: Jcc, JCXZ/LOOP family with count decrement,
// and a REP/REPZ/REPNZ iteration controller with registered results.
module jmp_cond_seq
  import jmp_cond_pkg::*;
#(
  parameter int CW    = 16,
  parameter int FLAGW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [3:0]       cond,
  input  logic [FLAGW-1:0] flags,
  input  logic [CW-1:0]    cnt_in,
  output logic             iter_req,
  input  logic             iter_ack,
  input  logic [FLAGW-1:0] iter_flags,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             jmp,
  output logic [CW-1:0]    cnt_out,
  output logic             cnt_we
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          iter_req_q, iter_req_d;
  logic          jmp_q, jmp_d;
  logic          cnt_we_q, cnt_we_d;
  logic [CW-1:0] cnt_out_q, cnt_out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;

  logic          jcc_taken;
  logic [CW-1:0] loop_cnt;
  logic [CW-1:0] rep_cnt;
  logic          loop_nz;
  logic          rep_stop;
  logic          unused_iter_flags;

  jmp_cond_eval #(.FLAGW(FLAGW)) u_eval (
    .flags (flags),
    .cond  (cond),
    .taken (jcc_taken)
  );

  assign loop_cnt = cnt_in - ONE;
  assign loop_nz  = (loop_cnt != '0);
  assign rep_cnt  = cnt_q - ONE;
  // Natural termination (count exhausted or flag condition) outranks abort
  assign rep_stop = (rep_cnt == '0)
                  | ((mode_q == REP_Z)  & ~iter_flags[FLAG_ZF])
                  | ((mode_q == REP_NZ) &  iter_flags[FLAG_ZF]);
  assign unused_iter_flags = ^iter_flags;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    iter_req_d  = iter_req_q;
    jmp_d       = jmp_q;
    cnt_we_d    = cnt_we_q;
    cnt_out_d   = cnt_out_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          case (op)
            OP_CX: begin
              state_d     = S_DONE;
              out_valid_d = 1'b1;
              if (cond[1:0] == CX_JCXZ) begin
                jmp_d    = (cnt_in == '0);
                cnt_we_d = 1'b0;
              end else begin
                cnt_out_d = loop_cnt;
                cnt_we_d  = 1'b1;
                case (cond[1:0])
                  CX_LOOPZ:  jmp_d = flags[FLAG_ZF] & loop_nz;
                  CX_LOOPNZ: jmp_d = ~flags[FLAG_ZF] & loop_nz;
                  default:   jmp_d = loop_nz;
                endcase
              end
            end
            OP_REP: begin
              state_d = S_REP_CHK;
              cnt_d   = cnt_in;
              mode_d  = cond[1:0];
            end
            default: begin
              state_d     = S_DONE;
              out_valid_d = 1'b1;
              jmp_d       = jcc_taken;
              cnt_we_d    = 1'b0;
            end
          endcase
        end
      end
      S_REP_CHK: begin
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          jmp_d       = 1'b0;
          cnt_we_d    = 1'b0;
          cnt_out_d   = cnt_q;
        end else begin
          state_d    = S_REP_RUN;
          iter_req_d = 1'b1;
        end
      end
      S_REP_RUN: begin
        if (iter_ack) begin
          cnt_d = rep_cnt;
          if (rep_stop || abort) begin
            state_d     = S_DONE;
            iter_req_d  = 1'b0;
            out_valid_d = 1'b1;
            cnt_out_d   = rep_cnt;
            cnt_we_d    = 1'b1;
            jmp_d       = abort & ~rep_stop;
          end
        end
      end
      default: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          jmp_d       = 1'b0;
          cnt_we_d    = 1'b0;
        end
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      iter_req_q  <= 1'b0;
      jmp_q       <= 1'b0;
      cnt_we_q    <= 1'b0;
      cnt_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      iter_req_q  <= iter_req_d;
      jmp_q       <= jmp_d;
      cnt_we_q    <= cnt_we_d;
      cnt_out_q   <= cnt_out_d;
    end
  end

  // Working count and REP mode are only meaningful inside a REP sequence
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    mode_q <= mode_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign iter_req  = iter_req_q;
  assign jmp       = jmp_q;
  assign cnt_we    = cnt_we_q;
  assign cnt_out   = cnt_out_q;

endmodule

// File: tb/tb_jmp_cond_seq.sv
// Randomized self-checking bench for jmp_cond_seq against a behavioural model.
module tb_jmp_cond_seq;

  localparam int CW    = 16;
  localparam int FLAGW = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       op = '0;
  logic [3:0]       cond = '0;
  logic [FLAGW-1:0] flags = '0;
  logic [CW-1:0]    cnt_in = '0;
  logic             iter_req;
  logic             iter_ack = 1'b0;
  logic [FLAGW-1:0] iter_flags = '0;
  logic             abort = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             jmp;
  logic [CW-1:0]    cnt_out;
  logic             cnt_we;

  int total = 0;
  int bad   = 0;

  jmp_cond_seq #(.CW(CW), .FLAGW(FLAGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cond(cond), .flags(flags), .cnt_in(cnt_in),
    .iter_req(iter_req), .iter_ack(iter_ack), .iter_flags(iter_flags),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .jmp(jmp), .cnt_out(cnt_out), .cnt_we(cnt_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // x86 condition table, flags = {of,sf,zf,pf,cf}
  function automatic bit ref_cc(input logic [3:0] c, input logic [4:0] f);
    bit o, s, z, p, cy;
    o = f[4]; s = f[3]; z = f[2]; p = f[1]; cy = f[0];
    case (c)
      4'h0: return o;
      4'h1: return !o;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return z;
      4'h5: return !z;
      4'h6: return cy || z;
      4'h7: return !cy && !z;
      4'h8: return s;
      4'h9: return !s;
      4'hA: return p;
      4'hB: return !p;
      4'hC: return s != o;
      4'hD: return s == o;
      4'hE: return z || (s != o);
      default: return !z && (s == o);
    endcase
  endfunction

  // One request; REP acks carry zf_plan[k-1] on the k-th ack, abort on ack abort_at
  task automatic txn(input logic [1:0] top, input logic [3:0] tcond, input logic [4:0] tflags,
                     input logic [15:0] tcnt, input logic [63:0] zf_plan, input int abort_at,
                     input int hold, input bit fast);
    bit e_jmp, e_we, other, ab, got;
    logic [15:0] e_cnt, d, c;
    logic [4:0] fl;
    int e_iters, acks, cyc, n;
    e_jmp = 0; e_we = 0; e_cnt = 0; e_iters = 0;
    if (top == 2'b01) begin
      if (tcond[1:0] == 2'b00) e_jmp = (tcnt == 0);
      else begin
        d = tcnt - 16'd1;
        e_cnt = d; e_we = 1;
        case (tcond[1:0])
          2'b01:   e_jmp = (d != 0);
          2'b10:   e_jmp = tflags[2] && (d != 0);
          default: e_jmp = !tflags[2] && (d != 0);
        endcase
      end
    end else if (top == 2'b10) begin
      for (int i = 1; i <= int'(tcnt); i++) begin
        c = tcnt - 16'(i);
        other = (c == 0) || (tcond[1:0] == 2'b10 && !zf_plan[i-1])
                         || (tcond[1:0] == 2'b11 && zf_plan[i-1]);
        ab = (i == abort_at);
        if (other || ab) begin
          e_iters = i; e_cnt = c; e_we = 1; e_jmp = ab && !other;
          break;
        end
      end
    end else begin
      e_jmp = ref_cc(tcond, tflags);
    end

    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; op = top; cond = tcond; flags = tflags; cnt_in = tcnt;
    @(posedge clk);
    #1;
    in_valid = 0; op = 2'($urandom); cond = 4'($urandom); cnt_in = 16'($urandom);
    flags = 5'($urandom);

    acks = 0; cyc = 0; got = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid) got = 1;
      else if (iter_req && (fast || $urandom_range(3) != 0)) begin
        acks++;
        fl = 5'($urandom);
        fl[2] = (acks <= 64) ? zf_plan[acks-1] : 1'b0;
        iter_ack = 1; iter_flags = fl; abort = (acks == abort_at);
      end else begin
        iter_ack = !iter_req && ($urandom_range(3) == 0);
        iter_flags = 5'($urandom);
        abort = ($urandom_range(3) == 0);
      end
    end
    iter_ack = 0; abort = 0;
    if (!got) begin
      check("result_timeout", 0, 1);
      return;
    end
    if (top != 2'b10) check("latency", cyc, 1);
    else check("rep_iters", acks, e_iters);
    check("jmp", jmp, e_jmp);
    check("cnt_we", cnt_we, e_we);
    if (e_we) check("cnt_out", cnt_out, e_cnt);
    check("in_ready_busy", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_jmp", jmp, e_jmp);
      check("hold_we", cnt_we, e_we);
      if (e_we) check("hold_cnt", cnt_out, e_cnt);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    check("valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    logic [1:0] rop;
    logic [15:0] rcnt;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_iter_req", iter_req, 0);
    check("rst_jmp", jmp, 0);
    check("rst_cnt_we", cnt_we, 0);
    check("rst_cnt_out", cnt_out, 0);
    rst = 1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 32; f++)
        txn($urandom_range(1) ? 2'b11 : 2'b00, 4'(c), 5'(f), 16'($urandom), 64'd0, 0, 0, 0);

    txn(2'b01, 4'b0001, 5'b00000, 16'd1, 64'd0, 0, 0, 0);
    txn(2'b01, 4'b0001, 5'b00000, 16'd0, 64'd0, 0, 0, 0);
    txn(2'b01, 4'b0011, 5'b00100, 16'd5, 64'd0, 0, 0, 0);
    txn(2'b01, 4'b0000, 5'b00000, 16'd0, 64'd0, 0, 0, 0);
    txn(2'b10, 4'b0000, 5'b00000, 16'd3, 64'd0, 0, 0, 1);
    txn(2'b10, 4'b0010, 5'b00000, 16'd10, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 1);
    txn(2'b10, 4'b0000, 5'b00000, 16'd0, 64'd0, 0, 0, 0);
    txn(2'b10, 4'b0001, 5'b00000, 16'd10, 64'd0, 4, 0, 0);
    txn(2'b10, 4'b0000, 5'b00000, 16'd3, 64'd0, 3, 0, 1);
    txn(2'b00, 4'b0100, 5'b00100, 16'd7, 64'd0, 0, 5, 0);

    for (int t = 0; t < 300; t++) begin
      rop = 2'($urandom_range(3));
      if (rop == 2'b10) rcnt = 16'($urandom_range(12));
      else if ($urandom_range(3) == 0) rcnt = 16'($urandom_range(1));
      else rcnt = 16'($urandom);
      txn(rop, 4'($urandom), 5'($urandom), rcnt, {$urandom, $urandom},
          $urandom_range(15), $urandom_range(3), 1'($urandom_range(1)));
    end

    // Reset while a REP sequence waits for its first ack
    @(negedge clk);
    in_valid = 1; op = 2'b10; cond = 4'b0000; cnt_in = 16'd10;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(negedge clk);
    check("midrep_req", iter_req, 1);
    rst = 0;
    @(negedge clk);
    check("midrep_rst_in_ready", in_ready, 0);
    check("midrep_rst_iter_req", iter_req, 0);
    check("midrep_rst_out_valid", out_valid, 0);
    check("midrep_rst_jmp", jmp, 0);
    check("midrep_rst_cnt_we", cnt_we, 0);
    check("midrep_rst_cnt_out", cnt_out, 0);
    rst = 1;
    @(negedge clk);
    check("midrep_recover", in_ready, 1);
    txn(2'b01, 4'b0010, 5'b00100, 16'd2, 64'd0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
